// File: rtl/sumador_pkg.sv
// sumador_pkg: shared definitions for the bit-serial adder.
//   state_t        - FSM states (IDLE, SHIFT, DONE)
//   WIDTH_DEFAULT  - default operand/result width
//   cnt_width()    - bit counter width for a given operand width (minimum 1)
package sumador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

  // $clog2(1) is 0, so small widths are clamped to a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/sumador_comp.sv
// sumador_comp: single-bit combinational full adder.
// Ports:
//   a, b  in  1  addend bits
//   cin   in  1  carry-in
//   sum   out 1  a ^ b ^ cin
//   cout  out 1  majority(a, b, cin)
module sumador_comp (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/sumador_serie.sv
// sumador_serie: bit-serial adder, one bit per clock, LSB first, built around
// a single sumador_comp full adder with a registered carry.
// Ports:
//   clk    in  1      rising-edge clock
//   rst_n  in  1      asynchronous active-low reset
//   start  in  1      request; accepted in IDLE or DONE only
//   a, b   in  WIDTH  operands, captured on the accepted start edge
//   cin    in  1      carry-in, captured on the accepted start edge
//   busy   out 1      high while the addition is in progress
//   done   out 1      one-cycle pulse when sum/cout are updated
//   sum    out WIDTH  last completed result
//   cout   out 1      last completed carry-out
module sumador_serie
  import sumador_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic             accept;
  // Result as it stands after the current bit is shifted in; on the last
  // SHIFT edge this is the complete sum.
  logic [WIDTH-1:0] res_full;

  assign accept = start && ((state == IDLE) || (state == DONE));

  sumador_comp u_comp (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Only WIDTH-1 result bits need storage: the newest bit comes straight
  // from the adder on the final edge.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_full = fa_sum;
    end else begin : g_res_wn
      logic [WIDTH-2:0] res_sr;

      assign res_full = {fa_sum, res_sr};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_sr <= '0;
        end else if (state == SHIFT) begin
          res_sr <= res_full[WIDTH-1:1];
        end else if (accept) begin
          res_sr <= '0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          // start is deliberately ignored here: no queuing, no re-capture.
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= fa_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= res_full;
            cout  <= fa_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
